stream_demux_1_4: RTL and testbench

- Registered 1-to-4 packet demultiplexer: the inverse of a 4:1 mux.
- Accepts a single upstream valid/ready stream with a last-beat marker.
- Steers each whole packet to one of four downstream valid/ready ports, chosen by sel on the first beat.
- Sits between a single producer and four consumers. Each output has a one-entry register slot, so data reaches the output exactly 1 cycle after acceptance.

---
 rtl/stream_demux_1_4.sv | 105 ++++++++++
 tb/tb_stream_demux_1_4.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 packet demultiplexer. The first beat's sel locks the destination port
// for the whole packet. Each output port has a one-entry slot.
module stream_demux_1_4 #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_valid,
    output logic            up_ready,
    input  logic [W-1:0]    up_data,
    input  logic            up_last,
    input  logic [1:0]      up_sel,
    output logic [3:0]      dn_valid,
    input  logic [3:0]      dn_ready,
    output logic [4*W-1:0]  dn_data,
    output logic [3:0]      dn_last,
    output logic            busy,
    output logic [1:0]      cur_sel,
    output logic [4*CW-1:0] pkt_cnt
);

    localparam logic StIdle = 1'b0;
    localparam logic StBusy = 1'b1;

    logic          state_q, state_d;
    logic [1:0]    cur_sel_q, cur_sel_d;
    logic [3:0]    valid_q, valid_d;
    logic [3:0]    last_q, last_d;
    logic [W-1:0]  data_q [4];
    logic [W-1:0]  data_d [4];
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [1:0]    tgt;
    logic          accept;

    always_comb begin
        tgt       = (state_q == StBusy) ? cur_sel_q : up_sel;
        up_ready  = ~rst & (~valid_q[tgt] | dn_ready[tgt]);
        accept    = up_valid & up_ready;
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        if (accept) begin
            if (state_q == StIdle && !up_last) begin
                state_d   = StBusy;
                cur_sel_d = up_sel;
            end else if (state_q == StBusy && up_last) begin
                state_d   = StIdle;
                cur_sel_d = 2'd0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            // A drain and a refill in the same cycle leave the slot valid with the new beat.
            valid_d[i] = valid_q[i] & ~dn_ready[i];
            last_d[i]  = last_q[i];
            data_d[i]  = data_q[i];
            cnt_d[i]   = cnt_q[i];
            if (accept && tgt == 2'(i)) begin
                valid_d[i] = 1'b1;
                last_d[i]  = up_last;
                data_d[i]  = up_data;
                if (up_last) begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cur_sel_q <= 2'd0;
            valid_q   <= 4'd0;
            last_q    <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    always_comb begin
        dn_data = '0;
        pkt_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            dn_data[i*W +: W]   = data_q[i];
            pkt_cnt[i*CW +: CW] = cnt_q[i];
        end
    end

    assign dn_valid = valid_q;
    assign dn_last  = last_q;
    assign busy     = (state_q == StBusy);
    assign cur_sel  = cur_sel_q;

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: directed vector table, reset/wrap sequences, and randomized
// traffic checked against a queue-based scoreboard model.
module tb_stream_demux_1_4;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            up_valid = 1'b0;
    logic            up_ready;
    logic [W-1:0]    up_data = '0;
    logic            up_last = 1'b0;
    logic [1:0]      up_sel = 2'd0;
    logic [3:0]      dn_valid;
    logic [3:0]      dn_ready = 4'd0;
    logic [4*W-1:0]  dn_data;
    logic [3:0]      dn_last;
    logic            busy;
    logic [1:0]      cur_sel;
    logic [4*CW-1:0] pkt_cnt;

    int tests = 0;
    int fails = 0;

    stream_demux_1_4 #(.W(W), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .up_valid (up_valid),
        .up_ready (up_ready),
        .up_data  (up_data),
        .up_last  (up_last),
        .up_sel   (up_sel),
        .dn_valid (dn_valid),
        .dn_ready (dn_ready),
        .dn_data  (dn_data),
        .dn_last  (dn_last),
        .busy     (busy),
        .cur_sel  (cur_sel),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [1:0] sel;
        logic [3:0] d;
        logic       last;
        logic [3:0] rdy;
        logic       e_rdy;
        logic [3:0] e_vld;
        logic       e_busy;
        logic [1:0] e_cur;
        logic [1:0] cport;
        logic [3:0] e_data;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [3:0] d,
                         input logic last, input logic [3:0] rdy);
        up_valid = v;
        up_sel   = sel;
        up_data  = d;
        up_last  = last;
        dn_ready = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard state for the randomized phase.
    logic [W:0] q [4][$];
    int         cnt [4];
    logic       in_pkt;
    logic [1:0] lock;

    initial begin
        logic [1:0] t;
        logic       e_rdy;
        logic [3:0] e_vld;

        //            v  sel d     last rdy    er  e_vld   eb ec   cp  ed
        tbl[0]  = '{1'b1, 2'd0, 4'hA, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 2'd0, 4'hA};
        tbl[1]  = '{1'b1, 2'd1, 4'hB, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b0, 2'd0, 2'd1, 4'hB};
        tbl[2]  = '{1'b1, 2'd2, 4'hC, 1'b1, 4'hF, 1'b1, 4'b0100, 1'b0, 2'd0, 2'd2, 4'hC};
        tbl[3]  = '{1'b1, 2'd3, 4'hD, 1'b1, 4'hF, 1'b1, 4'b1000, 1'b0, 2'd0, 2'd3, 4'hD};
        tbl[4]  = '{1'b0, 2'd0, 4'h0, 1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd3, 4'hD};
        tbl[5]  = '{1'b1, 2'd2, 4'h1, 1'b0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2, 4'h1};
        tbl[6]  = '{1'b1, 2'd0, 4'h2, 1'b0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2, 4'h2};
        tbl[7]  = '{1'b1, 2'd0, 4'h3, 1'b1, 4'hF, 1'b1, 4'b0100, 1'b0, 2'd0, 2'd2, 4'h3};
        tbl[8]  = '{1'b0, 2'd0, 4'h0, 1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd2, 4'h3};
        tbl[9]  = '{1'b1, 2'd1, 4'h5, 1'b1, 4'hD, 1'b1, 4'b0010, 1'b0, 2'd0, 2'd1, 4'h5};
        tbl[10] = '{1'b1, 2'd1, 4'h6, 1'b1, 4'hD, 1'b0, 4'b0010, 1'b0, 2'd0, 2'd1, 4'h5};
        tbl[11] = '{1'b1, 2'd1, 4'h6, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b0, 2'd0, 2'd1, 4'h6};
        tbl[12] = '{1'b0, 2'd0, 4'h0, 1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd1, 4'h6};
        tbl[13] = '{1'b1, 2'd0, 4'h7, 1'b1, 4'hE, 1'b1, 4'b0001, 1'b0, 2'd0, 2'd0, 4'h7};
        tbl[14] = '{1'b1, 2'd3, 4'h8, 1'b1, 4'hE, 1'b1, 4'b1001, 1'b0, 2'd0, 2'd3, 4'h8};
        tbl[15] = '{1'b0, 2'd3, 4'h0, 1'b0, 4'hE, 1'b1, 4'b0001, 1'b0, 2'd0, 2'd0, 4'h7};
        tbl[16] = '{1'b0, 2'd3, 4'h0, 1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 4'h7};

        // Reset with a pending upstream beat.
        drive(1'b1, 2'd0, 4'h0, 1'b1, 4'h0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_up_ready", 64'(up_ready), 64'd0);
        chk("rst_dn_valid", 64'(dn_valid), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_up_ready", 64'(up_ready), 64'd1);
        up_valid = 1'b0;
        @(posedge clk);
        #1;

        for (int r = 0; r < 17; r++) begin
            drive(tbl[r].v, tbl[r].sel, tbl[r].d, tbl[r].last, tbl[r].rdy);
            @(negedge clk);
            chk($sformatf("row%0d_up_ready", r), 64'(up_ready), 64'(tbl[r].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_dn_valid", r), 64'(dn_valid), 64'(tbl[r].e_vld));
            chk($sformatf("row%0d_busy", r), 64'(busy), 64'(tbl[r].e_busy));
            chk($sformatf("row%0d_cur_sel", r), 64'(cur_sel), 64'(tbl[r].e_cur));
            chk($sformatf("row%0d_data", r), 64'(dn_data[tbl[r].cport*W +: W]),
                64'(tbl[r].e_data));
        end
        chk("tbl_pkt_cnt", 64'(pkt_cnt), 64'h02_02_03_02);

        // Counter wrap on port 0.
        drive(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
        do_reset();
        for (int n = 0; n < 255; n++) begin
            drive(1'b1, 2'd0, 4'(n), 1'b1, 4'hF);
            @(posedge clk);
            #1;
        end
        chk("cnt_255", 64'(pkt_cnt[0 +: CW]), 64'd255);
        @(posedge clk);
        #1;
        chk("cnt_wrap", 64'(pkt_cnt), 64'd0);

        // Reset in the middle of a packet to port 1.
        drive(1'b1, 2'd1, 4'h9, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_cur_sel", 64'(cur_sel), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_dn_valid", 64'(dn_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_up_ready", 64'(up_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 2'd3, 4'h4, 1'b0, 4'hF);
        @(posedge clk);
        #1;
        chk("post_rst_dn_valid", 64'(dn_valid), 64'b1000);
        chk("post_rst_cur_sel", 64'(cur_sel), 64'd3);
        chk("post_rst_data", 64'(dn_data[3*W +: W]), 64'h4);
        drive(1'b1, 2'd0, 4'h5, 1'b1, 4'hF);
        @(posedge clk);
        #1;
        chk("post_rst_tail", 64'({dn_valid, dn_last[3], dn_data[3*W +: W], busy}),
            64'({4'b1000, 1'b1, 4'h5, 1'b0}));
        chk("post_rst_cnt", 64'(pkt_cnt), 64'h01_00_00_00);

        // Randomized traffic against the scoreboard.
        drive(1'b0, 2'd0, 4'h0, 1'b0, 4'hF);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            cnt[i] = 0;
        end
        in_pkt = 1'b0;
        lock   = 2'd0;
        for (int c = 0; c < 800; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom),
                  1'($urandom_range(0, 2) == 0), 4'($urandom));
            @(negedge clk);
            t     = in_pkt ? lock : up_sel;
            e_rdy = (q[t].size() == 0) || dn_ready[t];
            for (int i = 0; i < 4; i++) begin
                e_vld[i] = (q[i].size() != 0);
            end
            chk("rnd_up_ready", 64'(up_ready), 64'(e_rdy));
            chk("rnd_dn_valid", 64'(dn_valid), 64'(e_vld));
            chk("rnd_busy", 64'(busy), 64'(in_pkt));
            chk("rnd_cur_sel", 64'(cur_sel), 64'(in_pkt ? lock : 2'd0));
            for (int i = 0; i < 4; i++) begin
                chk("rnd_pkt_cnt", 64'(pkt_cnt[i*CW +: CW]), 64'(cnt[i] % 256));
                if (dn_valid[i] && dn_ready[i] && q[i].size() != 0) begin
                    chk("rnd_beat", 64'({dn_last[i], dn_data[i*W +: W]}), 64'(q[i][0]));
                    void'(q[i].pop_front());
                end
            end
            if (up_valid && e_rdy) begin
                q[t].push_back({up_last, up_data});
                if (up_last) begin
                    cnt[t]++;
                end
                if (!in_pkt && !up_last) begin
                    in_pkt = 1'b1;
                    lock   = up_sel;
                end else if (in_pkt && up_last) begin
                    in_pkt = 1'b0;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
